// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matmul_ctrl word-serial initiator.
package matmul_pkg;
  localparam int DATA_W      = 32;
  localparam int DEF_WORDS   = 256;
  localparam int DEF_TIMEOUT = 4096;

  typedef logic [3:0][7:0] mat_word_t;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    FIRE   = 3'd2,
    WAIT   = 3'd3,
    DRAIN  = 3'd4
  } ctrl_state_e;
endpackage

// File: rtl/matmul_word_buf.sv
// Serial-to-parallel matrix buffer: each write lands at the running index,
// and wrap_o flags the write that fills the last slot.
module matmul_word_buf
  import matmul_pkg::*;
#(
  parameter int WORDS = DEF_WORDS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  mat_word_t               data_i,
  output logic                    wrap_o,
  output logic [WORDS*DATA_W-1:0] words_o
);
  localparam int IDX_W = $clog2(WORDS);

  logic [IDX_W-1:0]             idx_q;
  logic [WORDS-1:0][DATA_W-1:0] mem_q;

  assign wrap_o  = we_i && (idx_q == IDX_W'(WORDS - 1));
  assign words_o = mem_q;

  // WORDS is a power of two, so the index wraps to 0 on its own after the last slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[idx_q] <= data_i;
      idx_q        <= idx_q + IDX_W'(1);
    end
  end
endmodule

// File: rtl/matmul_ctrl.sv
// Word-serial initiator for the multiply_long accelerator: loads A and B,
// pulses start, captures C on done (or times out), then streams C back out.
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int WORDS   = DEF_WORDS,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data,
  output logic                    out_last,
  output logic                    mult_start,
  output logic [WORDS*DATA_W-1:0] mult_A,
  output logic [WORDS*DATA_W-1:0] mult_B,
  input  logic [WORDS*DATA_W-1:0] mult_C,
  input  logic                    mult_done,
  output logic                    busy,
  output logic                    err
);
  localparam int IDX_W  = $clog2(WORDS);
  localparam int TCNT_W = $clog2(TIMEOUT);

  ctrl_state_e                  state_q;
  logic [IDX_W-1:0]             ridx_q, ridx_d;
  logic [TCNT_W-1:0]            tcnt_q, tcnt_d;
  logic [WORDS-1:0][DATA_W-1:0] c_q;
  logic                         in_ready_q, out_valid_q, out_last_q;
  logic [31:0]                  out_data_q;
  logic                         mult_start_q, busy_q, err_q;
  logic                         we_a, we_b, wrap_a, wrap_b;

  assign we_a   = in_valid && in_ready_q && (state_q == LOAD_A);
  assign we_b   = in_valid && in_ready_q && (state_q == LOAD_B);
  assign ridx_d = ridx_q + IDX_W'(1);
  assign tcnt_d = tcnt_q + TCNT_W'(1);

  matmul_word_buf #(.WORDS(WORDS)) u_buf_a (
    .clk(clk), .rst(rst), .we_i(we_a), .data_i(in_data), .wrap_o(wrap_a), .words_o(mult_A)
  );

  matmul_word_buf #(.WORDS(WORDS)) u_buf_b (
    .clk(clk), .rst(rst), .we_i(we_b), .data_i(in_data), .wrap_o(wrap_b), .words_o(mult_B)
  );

  // Control FSM with registered handshake, status and C readout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD_A;
      ridx_q       <= '0;
      tcnt_q       <= '0;
      c_q          <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      mult_start_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      mult_start_q <= 1'b0;
      case (state_q)
        LOAD_A: begin
          if (we_a) begin
            err_q <= 1'b0;
            if (wrap_a) state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (we_b) begin
            err_q <= 1'b0;
            if (wrap_b) begin
              state_q      <= FIRE;
              in_ready_q   <= 1'b0;
              busy_q       <= 1'b1;
              mult_start_q <= 1'b1;
              tcnt_q       <= '0;
            end
          end
        end
        // The timeout counter tracks cycles since the start pulse, FIRE included.
        FIRE: begin
          state_q <= WAIT;
          tcnt_q  <= tcnt_d;
        end
        WAIT: begin
          if (mult_done) begin
            c_q         <= mult_C;
            out_data_q  <= mult_C[DATA_W-1:0];
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            ridx_q      <= '0;
            state_q     <= DRAIN;
          end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
            err_q      <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= LOAD_A;
          end else begin
            tcnt_q <= tcnt_d;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              ridx_q      <= '0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= LOAD_A;
            end else begin
              ridx_q     <= ridx_d;
              out_data_q <= c_q[ridx_d];
              out_last_q <= (ridx_d == IDX_W'(WORDS - 1));
            end
          end
        end
        default: begin
          state_q     <= LOAD_A;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_data   = out_data_q;
  assign mult_start = mult_start_q;
  assign busy       = busy_q;
  assign err        = err_q;
endmodule
